dsp_share_arbiter: RTL and testbench
====================================

DSP_SHARE_ARBITER -- requirements
Module: dsp_share_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 18, meaning the width of the A and B operands.
REQ-002 SHALL have parameter PWIDTH, default 48, meaning the width of the C operand and the P result.
REQ-003 SHALL have parameter LATENCY, default 4, range 1..8, meaning the cycles from a dsp_valid cycle to the matching dsp_p.
REQ-004 SHALL have parameter IDLE_OPMODE, default 8'h00, meaning the opmode driven on bubble cycles.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have ports reqN_valid (in, 1), reqN_ready (out, 1), reqN_a (in, WIDTH), reqN_b (in, WIDTH), reqN_c (in, PWIDTH) and reqN_op (in, 8), for N = 0 and 1.
REQ-008 SHALL have ports dsp_a (out, WIDTH), dsp_b (out, WIDTH), dsp_c (out, PWIDTH), dsp_opmode (out, 8) and dsp_valid (out, 1): the issue bus to the shared slice, whose CE is tied high.
REQ-009 SHALL have port dsp_p, input, PWIDTH: the slice result.
REQ-010 SHALL have ports rsp0_valid (out, 1), rsp1_valid (out, 1) and rsp_p (out, PWIDTH): the result return to the requesters.
REQ-011 SHALL have ports busy (out, 1), high when any operation is in flight, and grant_last (out, 1), the id of the most recent grant.

Function
REQ-012 SHALL grant at most one requester per cycle; reqN_ready SHALL be combinational and high only for the granted requester; a transfer occurs when reqN_valid and reqN_ready are both high.
REQ-013 SHALL arbitrate as follows:
- one valid requester: grant it;
- both valid: grant the requester that is not grant_last (round-robin);
- neither valid: no grant.
REQ-014 SHALL update grant_last only on a transfer.
REQ-015 SHALL never stall: a valid request is always granted within 2 cycles, and back-to-back transfers every cycle are allowed.
REQ-016 SHALL, for a transfer in cycle T, register the operands so that in cycle T+1 dsp_a/b/c equal the request operands, dsp_opmode equals reqN_op and dsp_valid is 1.
REQ-017 SHALL drive a bubble in every cycle following a no-transfer cycle: dsp_valid 0, dsp_a/b/c 0, dsp_opmode IDLE_OPMODE.
REQ-018 SHALL keep a tag shift register LATENCY entries deep, each entry {valid, id}, shifted every cycle; entry 0 is loaded with {dsp_valid, id of the issued requester}.
REQ-019 SHALL drive rsp_p = dsp_p combinationally, and rspN_valid = last tag valid AND tag id == N.
REQ-020 SHALL therefore return each result exactly LATENCY cycles after its dsp_valid cycle, i.e. in cycle T+1+LATENCY.
REQ-021 SHALL return results in issue order; rsp0_valid and rsp1_valid SHALL never be high together.
REQ-022 SHALL drive busy = dsp_valid OR any tag valid.
REQ-023 SHALL let a requester deassert reqN_valid at any time without a transfer; an operation is not taken unless a transfer occurred.

Reset
REQ-024 SHALL, while rst_n = 0, immediately (no clock needed) clear these outputs: dsp_valid, dsp_a/b/c, all tags, rsp0_valid, rsp1_valid, busy and grant_last; dsp_opmode SHALL become IDLE_OPMODE.
REQ-025 SHALL force reqN_ready to 0 while rst_n = 0.
REQ-026 SHALL drop in-flight operations on reset mid-operation: no rspN_valid is produced for them after release.
REQ-027 SHALL, on the first rising edge after rst_n rises, arbitrate with grant_last = 1, so req0 wins a tie.

Verification (LATENCY = 4)
REQ-028 SHALL cover: single op, req0 a=3, b=5, op=8'h01 transfers at T -> dsp_valid=1, a=3, b=5 at T+1; rsp0_valid=1 only at T+5, with rsp_p = model value.
REQ-029 SHALL cover: both valid for 4 cycles after reset -> grants in order 0,1,0,1; rsp valids in order 0,1,0,1 at T+5..T+8; never both high.
REQ-030 SHALL cover: only req1 valid continuously for 6 cycles -> 6 consecutive grants to req1, no bubbles, busy high throughout.
REQ-031 SHALL cover: idle cycle between ops -> the bubble shows dsp_valid=0, dsp_opmode=8'h00, and the matching tag produces no rsp valid.
REQ-032 SHALL cover: rst_n driven low asynchronously 2 cycles after 3 transfers -> busy=0 immediately; no rsp valid after release; the next tie grants req0.
REQ-033 SHALL cover: req0 valid drops the cycle before its grant -> no transfer; req1 is served; grant_last is unchanged until a real transfer.

Source files
------------

// File: rtl/dsp_share_arbiter.sv
// Two-requester round-robin front end for one shared, fully pipelined DSP slice.
// Tags ride alongside the slice pipeline so each result returns to its issuer.
module dsp_share_arbiter #(
  parameter int          WIDTH       = 18,
  parameter int          PWIDTH      = 48,
  parameter int          LATENCY     = 4,
  parameter logic [7:0]  IDLE_OPMODE = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [PWIDTH-1:0] req0_c,
  input  logic [7:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [PWIDTH-1:0] req1_c,
  input  logic [7:0]        req1_op,
  output logic [WIDTH-1:0]  dsp_a,
  output logic [WIDTH-1:0]  dsp_b,
  output logic [PWIDTH-1:0] dsp_c,
  output logic [7:0]        dsp_opmode,
  output logic              dsp_valid,
  input  logic [PWIDTH-1:0] dsp_p,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [PWIDTH-1:0] rsp_p,
  output logic              busy,
  output logic              grant_last
);

  logic              g0;
  logic              g1;
  logic              last_eff;
  logic              seen_q, seen_d;
  logic              last_q, last_d;
  logic              v_q, v_d;
  logic              id_q, id_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [PWIDTH-1:0] c_q, c_d;
  logic [7:0]        op_q, op_d;
  logic [LATENCY-1:0] tv_q, tv_d;
  logic [LATENCY-1:0] tid_q, tid_d;

  // Round-robin grant; before any grant req1 counts as last so req0 wins a tie.
  always_comb begin
    last_eff = seen_q ? last_q : 1'b1;
    g0 = rst_n & req0_valid & (~req1_valid | last_eff);
    g1 = rst_n & req1_valid & (~req0_valid | ~last_eff);
  end

  assign req0_ready = g0;
  assign req1_ready = g1;

  // Issue register load, grant history and tag shift.
  always_comb begin
    v_d    = 1'b0;
    id_d   = 1'b0;
    a_d    = '0;
    b_d    = '0;
    c_d    = '0;
    op_d   = IDLE_OPMODE;
    last_d = last_q;
    seen_d = seen_q;
    unique case (1'b1)
      g0: begin
        v_d    = 1'b1;
        id_d   = 1'b0;
        a_d    = req0_a;
        b_d    = req0_b;
        c_d    = req0_c;
        op_d   = req0_op;
        last_d = 1'b0;
        seen_d = 1'b1;
      end
      g1: begin
        v_d    = 1'b1;
        id_d   = 1'b1;
        a_d    = req1_a;
        b_d    = req1_b;
        c_d    = req1_c;
        op_d   = req1_op;
        last_d = 1'b1;
        seen_d = 1'b1;
      end
      default: ;
    endcase
    tv_d     = '0;
    tid_d    = '0;
    tv_d[0]  = v_q;
    tid_d[0] = id_q;
    for (int i = 1; i < LATENCY; i++) begin
      tv_d[i]  = tv_q[i-1];
      tid_d[i] = tid_q[i-1];
    end
  end

  // State registers; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q <= 1'b0;
      last_q <= 1'b0;
      v_q    <= 1'b0;
      id_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      op_q   <= IDLE_OPMODE;
      tv_q   <= '0;
      tid_q  <= '0;
    end else begin
      seen_q <= seen_d;
      last_q <= last_d;
      v_q    <= v_d;
      id_q   <= id_d;
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      op_q   <= op_d;
      tv_q   <= tv_d;
      tid_q  <= tid_d;
    end
  end

  assign dsp_a      = a_q;
  assign dsp_b      = b_q;
  assign dsp_c      = c_q;
  assign dsp_opmode = op_q;
  assign dsp_valid  = v_q;
  assign rsp_p      = dsp_p;
  assign rsp0_valid = tv_q[LATENCY-1] & ~tid_q[LATENCY-1];
  assign rsp1_valid = tv_q[LATENCY-1] & tid_q[LATENCY-1];
  assign busy       = v_q | (|tv_q);
  assign grant_last = last_q;

endmodule

// File: tb/tb_dsp_share_arbiter.sv
// Bench for dsp_share_arbiter: slice model, arbitration model and
// a result scoreboard keyed by requester id in issue order.
module tb_dsp_share_arbiter;

  localparam int W = 18;
  localparam int PW = 48;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [PW-1:0] req0_c, req1_c;
  logic [7:0]    req0_op, req1_op;
  logic [W-1:0]  dsp_a, dsp_b;
  logic [PW-1:0] dsp_c, dsp_p, rsp_p;
  logic [7:0]    dsp_opmode;
  logic          dsp_valid, rsp0_valid, rsp1_valid, busy, grant_last;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic          id;
    logic [PW-1:0] p;
  } sb_t;
  sb_t sb[$];

  dsp_share_arbiter #(
    .WIDTH(W), .PWIDTH(PW), .LATENCY(LAT), .IDLE_OPMODE(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c), .req1_op(req1_op),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c),
    .dsp_opmode(dsp_opmode), .dsp_valid(dsp_valid), .dsp_p(dsp_p),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_p(rsp_p),
    .busy(busy), .grant_last(grant_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] slice(input logic [W-1:0] a,
      input logic [W-1:0] b, input logic [PW-1:0] c, input logic [7:0] op);
    logic [PW-1:0] r;
    r = PW'(a) * PW'(b);
    if (op[0]) r = r + c;
    return r;
  endfunction

  logic [PW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= slice(dsp_a, dsp_b, dsp_c, dsp_opmode);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dsp_p = pipe[LAT-1];

  logic          m_first, m_last;
  logic          prv_v;
  logic [W-1:0]  prv_a, prv_b;
  logic [PW-1:0] prv_c;
  logic [7:0]    prv_op;

  always @(negedge clk) begin : mon
    logic eff, e0, e1, eb;
    sb_t  s;
    if (!rst_n) begin
      sb.delete();
      m_first = 1'b1;
      m_last  = 1'b0;
      prv_v   = 1'b0;
    end else begin
      chk("dsp_valid", dsp_valid, prv_v);
      chk("dsp_a", dsp_a, prv_v ? prv_a : '0);
      chk("dsp_b", dsp_b, prv_v ? prv_b : '0);
      chk("dsp_c", dsp_c, prv_v ? prv_c : '0);
      chk("dsp_op", dsp_opmode, prv_v ? prv_op : 8'h00);
      chk("glast", grant_last, m_last);
      eb = (sb.size() != 0);
      chk("busy", busy, eb);
      if (rsp0_valid && rsp1_valid) chk("rsp_both", 1, 0);
      else if (rsp0_valid || rsp1_valid) begin
        if (sb.size() == 0) chk("rsp_spur", 1, 0);
        else begin
          s = sb.pop_front();
          chk("rsp_id", rsp1_valid, s.id);
          chk("rsp_p", rsp_p, s.p);
        end
      end
      eff = m_first ? 1'b1 : m_last;
      e0 = req0_valid && (!req1_valid || eff);
      e1 = req1_valid && (!req0_valid || !eff);
      chk("rdy0", req0_ready, e0);
      chk("rdy1", req1_ready, e1);
      prv_v = e0 || e1;
      if (e0) begin
        prv_a = req0_a; prv_b = req0_b; prv_c = req0_c; prv_op = req0_op;
        sb.push_back('{id: 1'b0, p: slice(req0_a, req0_b, req0_c, req0_op)});
        m_last = 1'b0; m_first = 1'b0;
      end else if (e1) begin
        prv_a = req1_a; prv_b = req1_b; prv_c = req1_c; prv_op = req1_op;
        sb.push_back('{id: 1'b1, p: slice(req1_a, req1_b, req1_c, req1_op)});
        m_last = 1'b1; m_first = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_ops();
    req0_a  = W'($urandom); req0_b = W'($urandom);
    req0_c  = {16'($urandom), 32'($urandom)}; req0_op = 8'($urandom);
    req1_a  = W'($urandom); req1_b = W'($urandom);
    req1_c  = {16'($urandom), 32'($urandom)}; req1_op = 8'($urandom);
  endtask

  task automatic drain(input int n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (n) cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    rnd_ops();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2;
    chk("rst_dsp_v", dsp_valid, 0);
    chk("rst_op", dsp_opmode, 8'h00);
    chk("rst_a", dsp_a, 0);
    chk("rst_busy", busy, 0);
    chk("rst_glast", grant_last, 0);
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    chk("rst_rsp", {rsp1_valid, rsp0_valid}, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;

    // single op from req0
    cyc();
    req0_valid = 1'b1;
    req0_a = 3; req0_b = 5; req0_c = 0; req0_op = 8'h01;
    #1;
    chk("s1_rdy", req0_ready, 1);
    cyc();
    req0_valid = 1'b0;
    chk("s1_v", dsp_valid, 1);
    chk("s1_a", dsp_a, 3);
    chk("s1_b", dsp_b, 5);
    chk("s1_op", dsp_opmode, 8'h01);
    for (int k = 2; k <= 6; k++) begin
      cyc();
      chk("s1_rsp0", rsp0_valid, k == 5);
      if (k == 5) chk("s1_p", rsp_p, 15);
    end
    drain(3);

    // tie after reset alternates starting with req0
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rnd_ops();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("s2_rdy0", req0_ready, (i % 2) == 0);
      chk("s2_rdy1", req1_ready, (i % 2) == 1);
      cyc();
    end
    drain(8);

    // req1 alone, back to back
    for (int i = 0; i < 6; i++) begin
      rnd_ops();
      req1_valid = 1'b1;
      #1;
      chk("s3_rdy1", req1_ready, 1);
      cyc();
      chk("s3_busy", busy, 1);
      chk("s3_v", dsp_valid, 1);
    end
    drain(8);
    chk("s3_idle", busy, 0);

    // bubble between ops
    rnd_ops();
    req0_valid = 1'b1;
    cyc();
    req0_valid = 1'b0;
    cyc();
    chk("s4_v", dsp_valid, 0);
    chk("s4_op", dsp_opmode, 8'h00);
    chk("s4_a", dsp_a, 0);
    rnd_ops();
    req1_valid = 1'b1;
    cyc();
    drain(8);

    // reset in the middle of three operations
    for (int i = 0; i < 3; i++) begin
      rnd_ops();
      req0_valid = 1'b1;
      cyc();
    end
    req0_valid = 1'b0;
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_busy", busy, 0);
    chk("s5_v", dsp_valid, 0);
    chk("s5_rsp", {rsp1_valid, rsp0_valid}, 0);
    chk("s5_glast", grant_last, 0);
    cyc();
    rst_n = 1'b1;
    rnd_ops();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("s5_rdy0", req0_ready, 1);
    chk("s5_rdy1", req1_ready, 0);
    cyc();
    drain(8);

    // req0 withdraws before its turn
    rnd_ops();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("s6_rdy1", req1_ready, 1);
    chk("s6_rdy0", req0_ready, 0);
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("s6_gl_a", grant_last, 1);
    cyc();
    chk("s6_gl_b", grant_last, 1);
    rnd_ops();
    req1_valid = 1'b1;
    #1;
    chk("s6_rdy1b", req1_ready, 1);
    cyc();
    req1_valid = 1'b0;
    chk("s6_gl_c", grant_last, 1);
    rnd_ops();
    req0_valid = 1'b1;
    cyc();
    req0_valid = 1'b0;
    chk("s6_gl_d", grant_last, 0);
    drain(8);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
